binary_gcd_lcm_engine: RTL and testbench
========================================

Name: binary_gcd_lcm_engine

Overview:
- Parametrised successor to the team's 8-bit binary (Stein) GCD state machine.
- Adds WIDTH-generic operands and a selectable LCM mode. LCM is computed as (Ain/GCD)*Bin using an internal restoring divider.
- Adds explicit zero-operand handling, deterministic reset values and a Busy flag.
- Sits under the top-level Nexys Starship game logic as a multi-cycle arithmetic coprocessor. Uses the same Start/Ack/CEN single-step handshake as the existing GCD block.

Parameters:
- WIDTH, 8, operand width in bits (legal range 4..32).
- CW, $clog2(WIDTH+1), localparam; width of the factor-of-2 counter.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin operation; sampled only in IDLE.
- Ack  input  1  acknowledge result; sampled only in DONE.
- CEN  input  1  step enable for SUB, MULT and DIV states (single-step support).
- Mode  input  1  0 = GCD, 1 = LCM; latched with operands.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B.
- A  output  WIDTH  working register A.
- B  output  WIDTH  working register B.
- Result  output  2*WIDTH  GCD (zero-extended) or LCM.
- i_count  output  CW  count of common factors of 2.
- Zero  output  1  an operand was zero.
- Busy  output  1  high in any state except IDLE and DONE.
- q_I, q_Sub, q_Mult, q_Div, q_Done  output  1 each  one-hot state bits.

Behaviour:
- Reset (async, Reset high):
  - state = IDLE.
  - A, B, Result, i_count, Zero and internal divider registers all = 0. No X assignments.
  - Reset mid-operation aborts immediately. No partial result survives.
- IDLE, every cycle:
  - A <= Ain, B <= Bin, i_count <= 0, Result <= 0, Zero <= 0, Mode latched.
  - If Start: go to DONE when Ain==0 or Bin==0, otherwise go to SUB.
- Zero path (IDLE to DONE directly):
  - Zero <= 1.
  - GCD mode: Result = the other operand; gcd(0,0) = 0.
  - LCM mode: Result = 0.
- SUB (acts only when CEN=1; frozen otherwise):
  - A==B: capture GCD = A. Next state is MULT if i_count != 0; else DIV (LCM mode) or DONE (GCD mode).
  - A<B: swap A and B.
  - A>B, both odd: A <= A-B.
  - Both even: A >>= 1, B >>= 1, i_count++.
  - Exactly one even: halve the even one only.
- MULT (CEN-gated):
  - Each step: GCD <<= 1, i_count--.
  - When i_count==1: next state is DIV (LCM mode) or DONE (GCD mode).
  - Exactly i_count steps.
- DIV (LCM mode only, CEN-gated):
  - Restoring division of the latched Ain by GCD; one quotient bit per enabled cycle; WIDTH steps.
  - After the final step: Result <= quotient * latched Bin (WIDTH x WIDTH to 2*WIDTH, single cycle); go to DONE.
  - GCD mode never enters DIV.
- DONE:
  - Result holds; GCD mode sets Result = zero-extended GCD.
  - If Ack: IDLE on the next edge.
  - Start is ignored in DONE.
  - Ack outside DONE is ignored.
- Latency (CEN=1, nonzero operands):
  - GCD: 1 (IDLE) + SUB steps + i_count.
  - LCM: the GCD latency plus WIDTH.
- Arithmetic:
  - All unsigned.
  - LCM never overflows 2*WIDTH bits.
  - Quotient fits in WIDTH bits because the divisor is at least 1.
- Illegal state encoding: go to IDLE on the next edge. No X propagation.

Optional Feature:
- Macro: GCD_STEP_COUNT_EN.
- When defined:
  - Adds output Steps [15:0]. Cleared in IDLE; increments on every enabled SUB/MULT/DIV cycle; saturates at 16'hFFFF; holds in DONE.
- When undefined:
  - Port absent; no counter logic.

Decomposition:
- Shared package gcd_pkg:
  - State encoding localparams IDLE=5'b00001, SUB=5'b00010, MULT=5'b00100, DIV=5'b01000, DONE=5'b10000.
  - MODE_GCD=1'b0, MODE_LCM=1'b1.
- Sub-module gcd_restoring_div, parametrised on WIDTH:
  - Inputs: load, step (=CEN), dividend, divisor.
  - Outputs: quotient, done.
  - Instantiated once by the engine.

Test Plan:
1. WIDTH=8, Mode=0, Ain=36, Bin=24, CEN=1, Start pulse -> Result=12, i_count peaks at 2, q_Done=1 until Ack; Ack -> q_I next cycle.
2. WIDTH=8, Mode=1, Ain=12, Bin=18 -> Result=36, DIV entered for exactly 8 enabled cycles, Zero=0.
3. Ain=0, Bin=45: Mode=0 -> Result=45, Zero=1, q_Done one cycle after Start; Mode=1 -> Result=0.
4. WIDTH=16, Mode=1, Ain=65535, Bin=65534 -> Result=4294770690, no truncation.
5. CEN held low for 10 cycles in SUB, then released -> A/B/state frozen, final Result unchanged vs CEN=1 run; Reset asserted mid-DIV -> all outputs 0, q_I=1 immediately.
6. Start held high through DONE, Ack pulsed -> no restart until IDLE is reached; new operation begins the cycle after return to IDLE.

Source files
------------

// File: rtl/binary_gcd_lcm_engine_pkg.sv
// Shared constants for the binary GCD/LCM engine: one-hot state encoding and mode values.
// Optional build macro used by the engine: GCD_STEP_COUNT_EN.
package gcd_pkg;

  typedef logic [4:0] state_t;

  localparam state_t IDLE = 5'b00001;
  localparam state_t SUB  = 5'b00010;
  localparam state_t MULT = 5'b00100;
  localparam state_t DIV  = 5'b01000;
  localparam state_t DONE = 5'b10000;

  localparam logic MODE_GCD = 1'b0;
  localparam logic MODE_LCM = 1'b1;

  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/binary_gcd_lcm_engine_if.sv
// Bus interface for the GCD/LCM engine; the Steps signal exists only with GCD_STEP_COUNT_EN.
// Handshake: Start is sampled only in IDLE (one op per sampled Start), the result is valid
// while q_Done is high, and Ack is sampled only in DONE to release it back to IDLE.
interface binary_gcd_lcm_engine_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic                 Start;
  logic                 Ack;
  logic                 CEN;
  logic                 Mode;
  logic [WIDTH-1:0]     Ain;
  logic [WIDTH-1:0]     Bin;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   Result;
  logic [CW-1:0]        i_count;
  logic                 Zero;
  logic                 Busy;
  logic                 q_I;
  logic                 q_Sub;
  logic                 q_Mult;
  logic                 q_Div;
  logic                 q_Done;
`ifdef GCD_STEP_COUNT_EN
  logic [15:0]          Steps;

  modport master (
    output Start, Ack, CEN, Mode, Ain, Bin,
    input  A, B, Result, i_count, Zero, Busy,
    input  q_I, q_Sub, q_Mult, q_Div, q_Done, Steps
  );

  modport slave (
    input  Start, Ack, CEN, Mode, Ain, Bin,
    output A, B, Result, i_count, Zero, Busy,
    output q_I, q_Sub, q_Mult, q_Div, q_Done, Steps
  );
`else
  modport master (
    output Start, Ack, CEN, Mode, Ain, Bin,
    input  A, B, Result, i_count, Zero, Busy,
    input  q_I, q_Sub, q_Mult, q_Div, q_Done
  );

  modport slave (
    input  Start, Ack, CEN, Mode, Ain, Bin,
    output A, B, Result, i_count, Zero, Busy,
    output q_I, q_Sub, q_Mult, q_Div, q_Done
  );
`endif

endinterface

// File: rtl/binary_gcd_lcm_engine_div.sv
// Restoring divider, one quotient bit per enabled step, WIDTH steps per division.
// quotient/done describe the step in progress so the caller can use the final quotient on that edge.
module gcd_restoring_div
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);
  localparam int CW = cw_of(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // The dividend is shifted out of the quotient register MSB-first as quotient bits fill in.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift[WIDTH-1:0] - r_div;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

  assign quotient = w_quo_next;
  assign done     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_div <= divisor;
      r_cnt <= '0;
    end else if (step) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/binary_gcd_lcm_engine.sv
// Multi-cycle binary (Stein) GCD with optional LCM = (Ain/GCD)*Bin via a restoring divider.
// Build macro GCD_STEP_COUNT_EN adds a saturating Steps counter on the bus.
module binary_gcd_lcm_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  binary_gcd_lcm_engine_if.slave bus
);
  localparam int CW = cw_of(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_gcd;
  logic [WIDTH-1:0]   r_ain;
  logic [WIDTH-1:0]   r_bin;
  logic [2*WIDTH-1:0] r_result;
  logic [CW-1:0]      r_count;
  logic               r_zero;
  logic               r_mode;

  logic               w_div_load;
  logic               w_div_step;
  logic               w_div_last;
  logic [WIDTH-1:0]   w_divisor;
  logic [WIDTH-1:0]   w_quotient;
  logic [2*WIDTH-1:0] w_product;

  // The divider is loaded on the same edge the FSM enters DIV, with the final GCD as divisor.
  always_comb begin
    w_div_load = 1'b0;
    w_divisor  = r_a;
    if (bus.CEN && r_mode == MODE_LCM) begin
      if (r_state == SUB && r_a == r_b && r_count == '0) begin
        w_div_load = 1'b1;
        w_divisor  = r_a;
      end else if (r_state == MULT && r_count <= CW'(1)) begin
        w_div_load = 1'b1;
        w_divisor  = r_gcd << 1;
      end
    end
  end

  assign w_div_step = bus.CEN && (r_state == DIV);
  assign w_product  = {{WIDTH{1'b0}}, w_quotient} * {{WIDTH{1'b0}}, r_bin};

  gcd_restoring_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (w_div_load),
    .step     (w_div_step),
    .dividend (r_ain),
    .divisor  (w_divisor),
    .quotient (w_quotient),
    .done     (w_div_last)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_gcd    <= '0;
      r_ain    <= '0;
      r_bin    <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_zero   <= 1'b0;
      r_mode   <= MODE_GCD;
    end else begin
      case (r_state)
        IDLE: begin
          r_a      <= bus.Ain;
          r_b      <= bus.Bin;
          r_ain    <= bus.Ain;
          r_bin    <= bus.Bin;
          r_gcd    <= '0;
          r_count  <= '0;
          r_result <= '0;
          r_zero   <= 1'b0;
          r_mode   <= bus.Mode;
          if (bus.Start) begin
            if (bus.Ain == '0 || bus.Bin == '0) begin
              // With one operand zero the OR is the other operand; gcd(0,0) falls out as 0.
              r_zero   <= 1'b1;
              r_result <= (bus.Mode == MODE_GCD) ? {{WIDTH{1'b0}}, bus.Ain | bus.Bin} : '0;
              r_state  <= DONE;
            end else begin
              r_state  <= SUB;
            end
          end
        end

        SUB: begin
          if (bus.CEN) begin
            if (r_a == r_b) begin
              r_gcd <= r_a;
              if (r_count != '0) begin
                r_state <= MULT;
              end else if (r_mode == MODE_LCM) begin
                r_state <= DIV;
              end else begin
                r_result <= {{WIDTH{1'b0}}, r_a};
                r_state  <= DONE;
              end
            end else if (r_a < r_b) begin
              r_a <= r_b;
              r_b <= r_a;
            end else if (r_a[0] && r_b[0]) begin
              r_a <= r_a - r_b;
            end else if (!r_a[0] && !r_b[0]) begin
              r_a     <= r_a >> 1;
              r_b     <= r_b >> 1;
              r_count <= r_count + CW'(1);
            end else if (!r_a[0]) begin
              r_a <= r_a >> 1;
            end else begin
              r_b <= r_b >> 1;
            end
          end
        end

        MULT: begin
          if (bus.CEN) begin
            r_gcd   <= r_gcd << 1;
            r_count <= r_count - CW'(1);
            if (r_count <= CW'(1)) begin
              if (r_mode == MODE_LCM) begin
                r_state <= DIV;
              end else begin
                r_result <= {{WIDTH{1'b0}}, (r_gcd << 1)};
                r_state  <= DONE;
              end
            end
          end
        end

        DIV: begin
          if (bus.CEN && w_div_last) begin
            r_result <= w_product;
            r_state  <= DONE;
          end
        end

        DONE: begin
          if (bus.Ack) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef GCD_STEP_COUNT_EN
  logic [15:0] r_steps;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_steps <= '0;
    end else if (r_state == IDLE) begin
      r_steps <= '0;
    end else if (bus.CEN && (r_state == SUB || r_state == MULT || r_state == DIV)
                 && r_steps != 16'hFFFF) begin
      r_steps <= r_steps + 16'd1;
    end
  end

  assign bus.Steps = r_steps;
`endif

  assign bus.A       = r_a;
  assign bus.B       = r_b;
  assign bus.Result  = r_result;
  assign bus.i_count = r_count;
  assign bus.Zero    = r_zero;
  assign bus.Busy    = !(r_state == IDLE || r_state == DONE);
  assign bus.q_I     = r_state[0];
  assign bus.q_Sub   = r_state[1];
  assign bus.q_Mult  = r_state[2];
  assign bus.q_Div   = r_state[3];
  assign bus.q_Done  = r_state[4];

endmodule

// File: tb/tb_binary_gcd_lcm_engine.sv
// Scoreboard bench for binary_gcd_lcm_engine: directed corner cases plus random operands
// checked against a Euclid-based GCD/LCM reference model.
module tb_binary_gcd_lcm_engine;
  localparam int W  = 8;
  localparam int W2 = 16;
  localparam int EW = 2 * W + 1;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  binary_gcd_lcm_engine_if #(.WIDTH(W))  bus8 ();
  binary_gcd_lcm_engine_if #(.WIDTH(W2)) bus16 ();

  binary_gcd_lcm_engine #(.WIDTH(W)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus8)
  );

  binary_gcd_lcm_engine #(.WIDTH(W2)) dut16 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus16)
  );

  int              n_checks = 0;
  int              n_errors = 0;
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   mon_e;
  logic            prev_done = 1'b0;
  int              div_cyc = 0;
  int              peak_cnt = 0;
  bit              cen_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // reference model: {zero_flag, result}
  function automatic logic [64:0] model(input longint unsigned a, input longint unsigned b,
                                        input bit mode);
    longint unsigned x, y, t;
    if (a == 0 || b == 0) return {1'b1, (mode ? 64'd0 : a + b)};
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return {1'b0, (mode ? (a / x) * b : x)};
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input bit mode);
    logic [64:0] m;
    m = model(longint'(a), longint'(b), mode);
    exp_q.push_back({m[64], m[2*W-1:0]});
  endtask

  // scoreboard monitor: one pop per rising q_Done
  always @(negedge Clk) begin
    if (bus8.q_Done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 64'(bus8.Result), 64'(mon_e[2*W-1:0]));
        check("zero_flag", 64'(bus8.Zero), 64'(mon_e[2*W]));
      end
    end
    prev_done = bus8.q_Done;
  end

  // per-operation statistics: enabled DIV steps and peak factor-of-2 count
  always @(posedge Clk) begin
    if (bus8.q_I && bus8.Start) begin
      div_cyc  = 0;
      peak_cnt = 0;
    end else begin
      if (bus8.q_Div && bus8.CEN) div_cyc++;
      if (int'(bus8.i_count) > peak_cnt) peak_cnt = int'(bus8.i_count);
    end
  end

  // driver tasks
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit mode);
    @(negedge Clk);
    bus8.Ain   = a;
    bus8.Bin   = b;
    bus8.Mode  = mode;
    bus8.Start = 1'b1;
    push_exp(a, b, mode);
    @(negedge Clk);
    bus8.Start = 1'b0;
    if (a == 0 || b == 0) check("zero_latency", 64'(bus8.q_Done), 64'd1);
    else check("busy_after_start", 64'(bus8.Busy), 64'd1);
  endtask

  task automatic finish_op();
    for (int i = 0; i < 3000 && !bus8.q_Done; i++) begin
      if (cen_rand) bus8.CEN = ($urandom_range(0, 3) != 0);
      @(negedge Clk);
    end
    bus8.CEN = 1'b1;
    if (!bus8.q_Done) begin
      check("done_timeout", 64'd0, 64'd1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      exp_q.delete();
      return;
    end
    repeat ($urandom_range(0, 3)) @(negedge Clk);
    check("done_held", 64'(bus8.q_Done), 64'd1);
    bus8.Ack = 1'b1;
    @(negedge Clk);
    bus8.Ack = 1'b0;
    check("ack_to_idle", 64'(bus8.q_I), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0]    m16;
    logic [W-1:0]   snap_a, snap_b, ra, rb;
    int             bad;

    Reset      = 1'b1;
    bus8.Start = 1'b0;  bus8.Ack = 1'b0;  bus8.CEN = 1'b1;  bus8.Mode = 1'b0;
    bus8.Ain   = 8'd5;  bus8.Bin = 8'd7;
    bus16.Start = 1'b0; bus16.Ack = 1'b0; bus16.CEN = 1'b1; bus16.Mode = 1'b0;
    bus16.Ain  = '0;    bus16.Bin = '0;

    // reset state
    repeat (2) @(negedge Clk);
    check("reset_q_I", 64'(bus8.q_I), 64'd1);
    check("reset_outputs", 64'({bus8.A, bus8.B, bus8.Result, bus8.i_count, bus8.Zero, bus8.Busy}), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_loads_A", 64'(bus8.A), 64'd5);

    // GCD 36,24 with an Ack pulse while busy
    start_op(8'd36, 8'd24, 1'b0);
    bus8.Ack = 1'b1;
    @(negedge Clk);
    bus8.Ack = 1'b0;
    check("ack_ignored_busy", 64'(bus8.Busy), 64'd1);
    finish_op();
    check("peak_i_count", 64'(peak_cnt), 64'd2);

    // LCM 12,18: DIV lasts exactly W enabled steps
    start_op(8'd12, 8'd18, 1'b1);
    finish_op();
    check("div_cycles", 64'(div_cyc), 64'(W));

    // zero operands
    start_op(8'd0, 8'd45, 1'b0);
    finish_op();
    start_op(8'd0, 8'd45, 1'b1);
    finish_op();
    start_op(8'd0, 8'd0, 1'b0);
    finish_op();

    // CEN low for 10 cycles in SUB
    start_op(8'd36, 8'd24, 1'b0);
    bus8.CEN = 1'b0;
    snap_a = bus8.A;
    snap_b = bus8.B;
    bad = 0;
    repeat (10) begin
      @(negedge Clk);
      if (bus8.A !== snap_a || bus8.B !== snap_b || bus8.q_Sub !== 1'b1) bad++;
    end
    check("sub_entry_a", 64'(snap_a), 64'd36);
    check("cen_freeze", 64'(bad), 64'd0);
    bus8.CEN = 1'b1;
    finish_op();

    // Reset mid-DIV aborts immediately
    start_op(8'd12, 8'd18, 1'b1);
    for (int i = 0; i < 200 && !bus8.q_Div; i++) @(negedge Clk);
    check("reached_div", 64'(bus8.q_Div), 64'd1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("reset_abort_outputs", 64'({bus8.A, bus8.B, bus8.Result, bus8.i_count, bus8.Zero,
          bus8.Busy, bus8.q_Sub, bus8.q_Mult, bus8.q_Div, bus8.q_Done}), 64'd0);
    check("reset_abort_idle", 64'(bus8.q_I), 64'd1);
    void'(exp_q.pop_back());
    @(negedge Clk);
    Reset = 1'b0;

    // Start held high through DONE
    @(negedge Clk);
    bus8.Ain = 8'd20;  bus8.Bin = 8'd8;  bus8.Mode = 1'b0;  bus8.Start = 1'b1;
    push_exp(8'd20, 8'd8, 1'b0);
    @(negedge Clk);
    for (int i = 0; i < 500 && !bus8.q_Done; i++) @(negedge Clk);
    check("held_start_done", 64'(bus8.q_Done), 64'd1);
    bad = 0;
    repeat (3) begin
      @(negedge Clk);
      if (bus8.q_Done !== 1'b1) bad++;
    end
    check("start_ignored_in_done", 64'(bad), 64'd0);
    bus8.Ain = 8'd9;  bus8.Bin = 8'd6;
    push_exp(8'd9, 8'd6, 1'b0);
    bus8.Ack = 1'b1;
    @(negedge Clk);
    bus8.Ack = 1'b0;
    check("ack_idle_start_held", 64'(bus8.q_I), 64'd1);
    @(negedge Clk);
    check("restart_after_idle", 64'(bus8.q_Sub), 64'd1);
    bus8.Start = 1'b0;
    finish_op();

    // random operands, CEN randomized on odd iterations
    for (int k = 0; k < 40; k++) begin
      cen_rand = (k % 2) == 1;
      ra = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      start_op(ra, rb, 1'($urandom_range(0, 1)));
      finish_op();
    end
    cen_rand = 1'b0;

    // WIDTH=16 LCM without truncation
    @(negedge Clk);
    bus16.Ain = 16'hFFFF;  bus16.Bin = 16'hFFFE;  bus16.Mode = 1'b1;  bus16.Start = 1'b1;
    m16 = model(64'd65535, 64'd65534, 1'b1);
    @(negedge Clk);
    bus16.Start = 1'b0;
    for (int i = 0; i < 3000 && !bus16.q_Done; i++) @(negedge Clk);
    check("lcm16_result", 64'(bus16.Result), m16[63:0]);
    check("lcm16_zero", 64'(bus16.Zero), 64'(m16[64]));
    bus16.Ack = 1'b1;
    @(negedge Clk);
    bus16.Ack = 1'b0;
    check("lcm16_ack_idle", 64'(bus16.q_I), 64'd1);

    repeat (5) @(negedge Clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
